// File: rtl/head_table_lookup.sv
// Head-table lookup: reads a bucket's head pointer from the head-table RAM and forwards the task downstream.
// Define HEAD_TABLE_CLEAR_ON_RESET_EN to sweep the RAM to zero after reset before accepting tasks.
module head_table_lookup #(
    parameter int unsigned RAM_LATENCY  = 2,
    parameter int unsigned A_WIDTH      = 8,
    parameter int unsigned BUCKET_WIDTH = 4,
    parameter int unsigned DATA_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [BUCKET_WIDTH-1:0] task_bucket_i,
    input  logic [DATA_WIDTH-1:0]   task_data_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,

    output logic [BUCKET_WIDTH-1:0] task_bucket_o,
    output logic [DATA_WIDTH-1:0]   task_data_o,
    output logic [A_WIDTH-1:0]      task_head_ptr_o,
    output logic                    task_head_ptr_val_o,
    output logic                    task_valid_o,
    input  logic                    task_ready_i,

    input  logic                    ht_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] ht_wr_addr_i,
    input  logic [A_WIDTH-1:0]      ht_wr_data_ptr_i,
    input  logic                    ht_wr_data_ptr_val_i
);

`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {INIT_S, IDLE_S, READ_S, OUT_S} state_e;
    localparam state_e RESET_STATE = INIT_S;
`else
    typedef enum logic [1:0] {IDLE_S, READ_S, OUT_S} state_e;
    localparam state_e RESET_STATE = IDLE_S;
`endif

    state_e                  state_q, state_d;
    logic [BUCKET_WIDTH-1:0] bucket_q, bucket_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [A_WIDTH-1:0]      ptr_q, ptr_d;
    logic                    ptr_val_q, ptr_val_d;
    logic                    fwd_q, fwd_d;
    logic                    issued_q, issued_d;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
    logic [BUCKET_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic [A_WIDTH:0]        mem [2**BUCKET_WIDTH];
    logic [A_WIDTH:0]        rd_data_q [RAM_LATENCY];
    logic [RAM_LATENCY-1:0]  rd_valid_q;
    logic                    rd_en;
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_waddr;
    logic [A_WIDTH:0]        ram_wdata;
    logic                    host_hit;

    // Read data returns RAM_LATENCY cycles after issue; a same-edge write is not visible to the read.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        rd_data_q[0] <= mem[bucket_q];
        for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
            rd_data_q[i] <= rd_data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= '0;
        end else begin
            rd_valid_q[0] <= rd_en;
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                rd_valid_q[i] <= rd_valid_q[i-1];
            end
        end
    end

    assign rd_en    = (state_q == READ_S) && !issued_q;
    assign host_hit = ht_wr_en_i && (ht_wr_addr_i == bucket_q);

    always_comb begin
        state_d   = state_q;
        bucket_d  = bucket_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        ptr_val_d = ptr_val_q;
        fwd_d     = fwd_q;
        issued_d  = issued_q;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
        clr_cnt_d = clr_cnt_q;
`endif
        ram_we    = 1'b0;
        ram_waddr = ht_wr_addr_i;
        ram_wdata = {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i};

        case (state_q)
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
            INIT_S: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = IDLE_S;
                end
            end
`endif
            IDLE_S: begin
                ram_we = ht_wr_en_i;
                if (task_valid_i) begin
                    bucket_d  = task_bucket_i;
                    data_d    = task_data_i;
                    ptr_d     = '0;
                    ptr_val_d = 1'b0;
                    fwd_d     = 1'b0;
                    issued_d  = 1'b0;
                    state_d   = READ_S;
                end
            end
            READ_S: begin
                ram_we   = ht_wr_en_i;
                issued_d = 1'b1;
                // RAM return first, then any same-cycle write hit so the write wins.
                if (rd_valid_q[RAM_LATENCY-1] && !fwd_q) begin
                    {ptr_d, ptr_val_d} = rd_data_q[RAM_LATENCY-1];
                end
                if (host_hit) begin
                    ptr_d     = ht_wr_data_ptr_i;
                    ptr_val_d = ht_wr_data_ptr_val_i;
                    fwd_d     = 1'b1;
                end
                if (rd_valid_q[RAM_LATENCY-1]) begin
                    state_d = OUT_S;
                end
            end
            OUT_S: begin
                ram_we = ht_wr_en_i;
                if (host_hit) begin
                    ptr_d     = ht_wr_data_ptr_i;
                    ptr_val_d = ht_wr_data_ptr_val_i;
                    fwd_d     = 1'b1;
                end
                if (task_ready_i) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RESET_STATE;
            bucket_q  <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
            ptr_val_q <= 1'b0;
            fwd_q     <= 1'b0;
            issued_q  <= 1'b0;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bucket_q  <= bucket_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            ptr_val_q <= ptr_val_d;
            fwd_q     <= fwd_d;
            issued_q  <= issued_d;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    // Ready is held low while reset is asserted, even if the reset state is IDLE_S.
    assign task_ready_o        = (state_q == IDLE_S) && !rst_i;
    assign task_valid_o        = (state_q == OUT_S);
    assign task_bucket_o       = bucket_q;
    assign task_data_o         = data_q;
    assign task_head_ptr_o     = ptr_q;
    assign task_head_ptr_val_o = ptr_val_q;

endmodule

// File: tb/tb_head_table_lookup.sv
// Directed bench for head_table_lookup: table of lookups plus forwarding, stall, back-to-back and reset sequences.
module tb_head_table_lookup;

    localparam int RL = 2;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam int DW = 16;
`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
    localparam int RDY_LAT = 2**BW;
`else
    localparam int RDY_LAT = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [BW-1:0] task_bucket_i = '0;
    logic [DW-1:0] task_data_i = '0;
    logic          task_valid_i = 1'b0;
    logic          task_ready_o;
    logic [BW-1:0] task_bucket_o;
    logic [DW-1:0] task_data_o;
    logic [AW-1:0] task_head_ptr_o;
    logic          task_head_ptr_val_o;
    logic          task_valid_o;
    logic          task_ready_i = 1'b0;
    logic          ht_wr_en_i = 1'b0;
    logic [BW-1:0] ht_wr_addr_i = '0;
    logic [AW-1:0] ht_wr_data_ptr_i = '0;
    logic          ht_wr_data_ptr_val_i = 1'b0;

    head_table_lookup #(
        .RAM_LATENCY (RL),
        .A_WIDTH     (AW),
        .BUCKET_WIDTH(BW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .task_bucket_i       (task_bucket_i),
        .task_data_i         (task_data_i),
        .task_valid_i        (task_valid_i),
        .task_ready_o        (task_ready_o),
        .task_bucket_o       (task_bucket_o),
        .task_data_o         (task_data_o),
        .task_head_ptr_o     (task_head_ptr_o),
        .task_head_ptr_val_o (task_head_ptr_val_o),
        .task_valid_o        (task_valid_o),
        .task_ready_i        (task_ready_i),
        .ht_wr_en_i          (ht_wr_en_i),
        .ht_wr_addr_i        (ht_wr_addr_i),
        .ht_wr_data_ptr_i    (ht_wr_data_ptr_i),
        .ht_wr_data_ptr_val_i(ht_wr_data_ptr_val_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [BW-1:0] bucket;
        logic [DW-1:0] data;
        logic [AW-1:0] exp_ptr;
        logic          exp_val;
    } vec_t;

    vec_t vecs [5];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic hwrite(input logic [BW-1:0] a, input logic [AW-1:0] p, input logic v);
        ht_wr_en_i = 1'b1;
        ht_wr_addr_i = a;
        ht_wr_data_ptr_i = p;
        ht_wr_data_ptr_val_i = v;
        tick();
        ht_wr_en_i = 1'b0;
    endtask

    // Returns at the falling edge of the cycle after acceptance.
    task automatic accept(input logic [BW-1:0] b, input logic [DW-1:0] d);
        int w = 0;
        task_bucket_i = b;
        task_data_i = d;
        task_valid_i = 1'b1;
        while (!task_ready_o && w < 100) begin
            tick();
            w++;
        end
        if (!task_ready_o) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        task_valid_i = 1'b0;
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (!task_valid_o && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        task_ready_i = 1'b1;
        tick();
        task_ready_i = 1'b0;
        chk("valid_drop", {31'd0, task_valid_o}, 32'd0);
    endtask

    task automatic check_ready_after_reset(input string name);
        int cnt = 0;
        bit seen_valid = 1'b0;
        int first = -1;
        rst_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cnt++;
            if (task_valid_o) seen_valid = 1'b1;
            if (task_ready_o && first < 0) first = cnt;
        end
        chk({name, "_ready_lat"}, first, RDY_LAT);
        chk({name, "_no_valid"}, {31'd0, seen_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int acc [3];
        int in_i, out_i;
        bit accepted;
        bit seen_valid;
        logic [AW-1:0] exp3_ptr;
        logic          exp3_val;

        vecs[0] = '{4'd5,  16'h1111, 8'h00, 1'b0};
        vecs[1] = '{4'd3,  16'hBEEF, 8'h12, 1'b1};
        vecs[2] = '{4'd9,  16'h0001, 8'hA5, 1'b1};
        vecs[3] = '{4'd12, 16'hFFFF, 8'h3C, 1'b0};
        vecs[4] = '{4'd8,  16'h8888, 8'h55, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_ready", {31'd0, task_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, task_valid_o}, 32'd0);
        chk("rst_data", {16'd0, task_data_o}, 32'd0);
        chk("rst_ptr", {24'd0, task_head_ptr_o}, 32'd0);
        check_ready_after_reset("init");

`ifndef HEAD_TABLE_CLEAR_ON_RESET_EN
        hwrite(4'd5, 8'h00, 1'b0);
`endif
        hwrite(4'd3, 8'h12, 1'b1);
        hwrite(4'd9, 8'hA5, 1'b1);
        hwrite(4'd12, 8'h3C, 1'b0);

        // Table-driven lookups
        for (int i = 0; i < 4; i++) begin
            accept(vecs[i].bucket, vecs[i].data);
            wait_out(1, lat);
            chk($sformatf("v%0d_latency", i), lat, RL + 2);
            chk($sformatf("v%0d_ptr", i), {24'd0, task_head_ptr_o}, {24'd0, vecs[i].exp_ptr});
            chk($sformatf("v%0d_val", i), {31'd0, task_head_ptr_val_o}, {31'd0, vecs[i].exp_val});
            chk($sformatf("v%0d_bucket", i), {28'd0, task_bucket_o}, {28'd0, vecs[i].bucket});
            chk($sformatf("v%0d_data", i), {16'd0, task_data_o}, {16'd0, vecs[i].data});
            handshake();
        end

        // Back-to-back with valid and ready held high
        task_ready_i = 1'b1;
        in_i = 0;
        out_i = 0;
        accepted = 1'b0;
        task_bucket_i = vecs[1].bucket;
        task_data_i = vecs[1].data;
        task_valid_i = 1'b1;
        for (int cyc = 0; cyc < 80 && out_i < 3; cyc++) begin
            if (task_valid_o) begin
                chk($sformatf("bb%0d_data", out_i), {16'd0, task_data_o}, {16'd0, vecs[out_i+1].data});
                chk($sformatf("bb%0d_ptr", out_i), {24'd0, task_head_ptr_o}, {24'd0, vecs[out_i+1].exp_ptr});
                out_i++;
            end
            if (task_ready_o && task_valid_i) begin
                acc[in_i] = cyc;
                accepted = 1'b1;
            end
            tick();
            if (accepted) begin
                accepted = 1'b0;
                in_i++;
                if (in_i < 3) begin
                    task_bucket_i = vecs[in_i+1].bucket;
                    task_data_i = vecs[in_i+1].data;
                end else begin
                    task_valid_i = 1'b0;
                end
            end
        end
        task_ready_i = 1'b0;
        task_valid_i = 1'b0;
        chk("bb_count", out_i, 3);
        chk("bb_spacing01", acc[1] - acc[0], RL + 3);
        chk("bb_spacing12", acc[2] - acc[1], RL + 3);

        // Write in the read-issue cycle must override the RAM value
        hwrite(4'd7, 8'h99, 1'b1);
        accept(4'd7, 16'h7777);
        hwrite(4'd7, 8'h21, 1'b1);
        wait_out(2, lat);
        chk("fwd_issue_latency", lat, RL + 2);
        chk("fwd_issue_ptr", {24'd0, task_head_ptr_o}, 32'h21);
        chk("fwd_issue_val", {31'd0, task_head_ptr_val_o}, 32'd1);
        chk("fwd_issue_data", {16'd0, task_data_o}, 32'h7777);
        handshake();

        // Stall in OUT_S with writes to the same and another bucket
        accept(4'd7, 16'h7070);
        wait_out(1, lat);
        chk("stall_latency", lat, RL + 2);
        chk("stall_initial_ptr", {24'd0, task_head_ptr_o}, 32'h21);
        seen_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ht_wr_en_i = 1'b0;
            if (k == 2) begin
                ht_wr_en_i = 1'b1; ht_wr_addr_i = 4'd7; ht_wr_data_ptr_i = 8'h33; ht_wr_data_ptr_val_i = 1'b0;
            end else if (k == 4) begin
                ht_wr_en_i = 1'b1; ht_wr_addr_i = 4'd7; ht_wr_data_ptr_i = 8'h34; ht_wr_data_ptr_val_i = 1'b1;
            end else if (k == 6) begin
                ht_wr_en_i = 1'b1; ht_wr_addr_i = 4'd8; ht_wr_data_ptr_i = 8'h55; ht_wr_data_ptr_val_i = 1'b1;
            end
            tick();
            if (!task_valid_o) seen_valid = 1'b0;
        end
        ht_wr_en_i = 1'b0;
        chk("stall_valid_held", {31'd0, seen_valid}, 32'd1);
        chk("stall_ptr", {24'd0, task_head_ptr_o}, 32'h34);
        chk("stall_val", {31'd0, task_head_ptr_val_o}, 32'd1);
        chk("stall_data", {16'd0, task_data_o}, 32'h7070);
        chk("stall_bucket", {28'd0, task_bucket_o}, 32'd7);
        handshake();

        // The write to bucket 8 during the stall reached the RAM
        accept(vecs[4].bucket, vecs[4].data);
        wait_out(1, lat);
        chk("b8_ptr", {24'd0, task_head_ptr_o}, {24'd0, vecs[4].exp_ptr});
        chk("b8_val", {31'd0, task_head_ptr_val_o}, {31'd0, vecs[4].exp_val});
        handshake();

        // Reset during READ_S discards the in-flight task
        accept(4'd3, 16'h3333);
        rst_i = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, task_valid_o}, 32'd0);
        chk("midrst_ready", {31'd0, task_ready_o}, 32'd0);
        chk("midrst_data", {16'd0, task_data_o}, 32'd0);
        check_ready_after_reset("midrst");

`ifdef HEAD_TABLE_CLEAR_ON_RESET_EN
        exp3_ptr = 8'h00;
        exp3_val = 1'b0;
`else
        exp3_ptr = 8'h12;
        exp3_val = 1'b1;
`endif
        accept(4'd3, 16'h3A3A);
        wait_out(1, lat);
        chk("post_rst_latency", lat, RL + 2);
        chk("post_rst_ptr", {24'd0, task_head_ptr_o}, {24'd0, exp3_ptr});
        chk("post_rst_val", {31'd0, task_head_ptr_val_o}, {31'd0, exp3_val});
        chk("post_rst_data", {16'd0, task_data_o}, 32'h3A3A);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
